// File: rtl/watch_core_cfg.sv
// HH:MM:SS timekeeper with mode/add/sub set-time FSM, 12/24-hour display, set timeout and blink.
// Optional WATCH_HOLD_REPEAT_EN: a held add/sub button auto-repeats on pulse_500ms in set states.
module watch_core_cfg #(
    parameter int unsigned HOUR_12       = 0,
    parameter int unsigned INIT_HH       = 0,
    parameter int unsigned INIT_MM       = 0,
    parameter int unsigned INIT_SS       = 0,
    parameter int unsigned SET_TIMEOUT_S = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pulse_1hz,
    input  logic       pulse_500ms,
    input  logic       mode_button,
    input  logic       add_button,
    input  logic       sub_button,
    output logic [5:0] d1,
    output logic [5:0] d2,
    output logic [5:0] d3,
    output logic [5:0] d4,
    output logic [5:0] d5,
    output logic [5:0] d6,
    output logic [5:0] d7,
    output logic [5:0] d8,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       set_active
);

    typedef enum logic [1:0] {StRun, StSetHh, StSetMm, StSetSs} state_e;

    localparam int unsigned TW = (SET_TIMEOUT_S < 1) ? 1 : $clog2(SET_TIMEOUT_S + 1);

    state_e        state_q;
    logic [4:0]    hh_q;
    logic [5:0]    mm_q;
    logic [5:0]    ss_q;
    logic          phase_q;
    logic [TW-1:0] tcnt_q;
    logic          mode_prev_q;
    logic          add_prev_q;
    logic          sub_prev_q;

    logic       mode_edge;
    logic       add_edge;
    logic       sub_edge;
    logic       any_edge;
    logic       edit_edge;
    logic       in_set;
    logic       timeout_hit;
    logic       tick;
    logic       rep_fire;
    logic       rep_up;
    logic       step_up;
    logic       step_en;
    logic [4:0] hh_step;
    logic [5:0] mm_step;
    logic [5:0] ss_step;

    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top,
                                             input logic up);
        logic [5:0] r;
        if (up) r = (v >= top) ? 6'd0 : v + 6'd1;
        else    r = (v == 6'd0) ? top : v - 6'd1;
        return r;
    endfunction

    // {tens, units} of a 0..59 value
    function automatic logic [7:0] split(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    // Packed {d8, d7, ..., d1}
    function automatic logic [47:0] decode(input state_e st, input logic [4:0] h,
                                           input logic [5:0] m, input logic [5:0] s,
                                           input logic ph);
        logic [4:0] dh;
        logic       pm;
        logic       eh;
        logic       em;
        logic       es;
        logic       colon;
        logic [7:0] hb;
        logic [7:0] mb;
        logic [7:0] sb;
        pm = (h >= 5'd12);
        dh = h;
        if (HOUR_12 != 0) begin
            if (pm) dh = h - 5'd12;
            if (dh == 5'd0) dh = 5'd12;
        end
        hb = split({1'b0, dh});
        mb = split(m);
        sb = split(s);
        eh = !((st == StSetHh) && !ph);
        em = !((st == StSetMm) && !ph);
        es = !((st == StSetSs) && !ph);
        // Colons blink with the phase only while running; steady while editing.
        colon = (st == StRun) ? ph : 1'b1;
        return {eh, hb[7:4], 1'b0, eh, hb[3:0], colon, 6'd0,
                em, mb[7:4], colon, em, mb[3:0], 1'b0, 6'd0,
                es, sb[7:4], 1'b0, es, sb[3:0], (HOUR_12 != 0) && pm};
    endfunction

    assign mode_edge   = mode_button && !mode_prev_q;
    assign add_edge    = add_button && !add_prev_q;
    assign sub_edge    = sub_button && !sub_prev_q;
    assign any_edge    = mode_edge || add_edge || sub_edge;
    assign edit_edge   = add_edge ^ sub_edge;
    assign in_set      = (state_q != StRun);
    assign timeout_hit = (SET_TIMEOUT_S != 0) && in_set && (tcnt_q == TW'(SET_TIMEOUT_S));
    assign tick        = !in_set && pulse_1hz;
    assign step_up     = edit_edge ? add_edge : rep_up;
    assign step_en     = in_set && !mode_edge && !timeout_hit && (edit_edge || rep_fire);
    assign hh_step     = 5'(wrap_step({1'b0, hh_q}, 6'd23, step_up));
    assign mm_step     = wrap_step(mm_q, 6'd59, step_up);
    assign ss_step     = wrap_step(ss_q, 6'd59, step_up);
    assign set_active  = in_set;

`ifdef WATCH_HOLD_REPEAT_EN
    logic       rep_act_q;
    logic       rep_up_q;
    logic       rep_held;
    logic [1:0] rep_cnt_q;

    assign rep_held = rep_up_q ? add_button : sub_button;
    // Two pulse_500ms arm the repeat; every later one steps while still held.
    assign rep_fire = rep_act_q && rep_held && pulse_500ms && (rep_cnt_q == 2'd2);
    assign rep_up   = rep_up_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rep_act_q <= 1'b0;
            rep_up_q  <= 1'b0;
            rep_cnt_q <= 2'd0;
        end else if (!in_set || mode_edge || timeout_hit) begin
            rep_act_q <= 1'b0;
        end else if (edit_edge) begin
            rep_act_q <= 1'b1;
            rep_up_q  <= add_edge;
            rep_cnt_q <= 2'd0;
        end else if (add_edge && sub_edge) begin
            rep_act_q <= 1'b0;
        end else if (rep_act_q && !rep_held) begin
            rep_act_q <= 1'b0;
        end else if (rep_act_q && pulse_500ms && rep_cnt_q != 2'd2) begin
            rep_cnt_q <= rep_cnt_q + 2'd1;
        end
    end
`else
    assign rep_fire = 1'b0;
    assign rep_up   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            hh_q        <= 5'(INIT_HH);
            mm_q        <= 6'(INIT_MM);
            ss_q        <= 6'(INIT_SS);
            phase_q     <= 1'b1;
            tcnt_q      <= '0;
            mode_prev_q <= 1'b0;
            add_prev_q  <= 1'b0;
            sub_prev_q  <= 1'b0;
            {d8, d7, d6, d5, d4, d3, d2, d1} <=
                decode(StRun, 5'(INIT_HH), 6'(INIT_MM), 6'(INIT_SS), 1'b1);
            hours       <= 5'(INIT_HH);
            minutes     <= 6'(INIT_MM);
            seconds     <= 6'(INIT_SS);
        end else begin
            mode_prev_q <= mode_button;
            add_prev_q  <= add_button;
            sub_prev_q  <= sub_button;

            if (mode_edge) begin
                case (state_q)
                    StRun:   state_q <= StSetHh;
                    StSetHh: state_q <= StSetMm;
                    StSetMm: state_q <= StSetSs;
                    default: state_q <= StRun;
                endcase
            end else if (timeout_hit) begin
                state_q <= StRun;
            end

            if (mode_edge || timeout_hit || any_edge) begin
                tcnt_q <= '0;
            end else if (in_set && pulse_1hz && (SET_TIMEOUT_S != 0) &&
                         (tcnt_q != TW'(SET_TIMEOUT_S))) begin
                tcnt_q <= tcnt_q + TW'(1);
            end

            if (any_edge)         phase_q <= 1'b1;
            else if (pulse_500ms) phase_q <= ~phase_q;

            if (tick) begin
                if (ss_q == 6'd59) begin
                    ss_q <= 6'd0;
                    if (mm_q == 6'd59) begin
                        mm_q <= 6'd0;
                        hh_q <= (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
                    end else begin
                        mm_q <= mm_q + 6'd1;
                    end
                end else begin
                    ss_q <= ss_q + 6'd1;
                end
            end else if (step_en) begin
                case (state_q)
                    StSetHh: hh_q <= hh_step;
                    StSetMm: mm_q <= mm_step;
                    StSetSs: ss_q <= ss_step;
                    default: ;
                endcase
            end

            {d8, d7, d6, d5, d4, d3, d2, d1} <= decode(state_q, hh_q, mm_q, ss_q, phase_q);
            hours   <= hh_q;
            minutes <= mm_q;
            seconds <= ss_q;
        end
    end

endmodule

// File: tb/tb_watch_core_cfg.sv
// Bench for watch_core_cfg: 24h and 12h instances against a time-arithmetic reference model.
module tb_watch_core_cfg;

    localparam int TO = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic pulse_1hz = 1'b0;
    logic pulse_500ms = 1'b0;
    logic mode_button = 1'b0;
    logic add_button = 1'b0;
    logic sub_button = 1'b0;

    logic [5:0] a1, a2, a3, a4, a5, a6, a7, a8;
    logic [5:0] b1, b2, b3, b4, b5, b6, b7, b8;
    logic [4:0] hours_a, hours_b;
    logic [5:0] minutes_a, minutes_b, seconds_a, seconds_b;
    logic       set_active_a, set_active_b;

    int n_err = 0;
    int n_checks = 0;
    bit cmp_en = 1'b0;

    always #5 clock = ~clock;

    watch_core_cfg #(
        .HOUR_12(0), .INIT_HH(23), .INIT_MM(59), .INIT_SS(58), .SET_TIMEOUT_S(TO)
    ) u_dut24 (
        .clock(clock), .reset(reset), .pulse_1hz(pulse_1hz), .pulse_500ms(pulse_500ms),
        .mode_button(mode_button), .add_button(add_button), .sub_button(sub_button),
        .d1(a1), .d2(a2), .d3(a3), .d4(a4), .d5(a5), .d6(a6), .d7(a7), .d8(a8),
        .hours(hours_a), .minutes(minutes_a), .seconds(seconds_a), .set_active(set_active_a)
    );

    watch_core_cfg #(
        .HOUR_12(1), .INIT_HH(23), .INIT_MM(59), .INIT_SS(58), .SET_TIMEOUT_S(TO)
    ) u_dut12 (
        .clock(clock), .reset(reset), .pulse_1hz(pulse_1hz), .pulse_500ms(pulse_500ms),
        .mode_button(mode_button), .add_button(add_button), .sub_button(sub_button),
        .d1(b1), .d2(b2), .d3(b3), .d4(b4), .d5(b5), .d6(b6), .d7(b7), .d8(b8),
        .hours(hours_b), .minutes(minutes_b), .seconds(seconds_b), .set_active(set_active_b)
    );

    // Reference model: state 0=run, 1=set hours, 2=set minutes, 3=set seconds
    int m_st, m_h, m_m, m_s, m_tc, r_n;
    bit m_ph, pv_mode, pv_add, pv_sub, r_act, r_up;
    logic [47:0] x24, x12;
    int xh, xm, xs;

    function automatic logic [47:0] model_disp(input bit h12, input int st, input int h,
                                               input int m, input int s, input bit ph);
        int dh;
        bit pm, eh, em, es, col;
        pm  = (h >= 12);
        dh  = h12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
        eh  = !(st == 1 && !ph);
        em  = !(st == 2 && !ph);
        es  = !(st == 3 && !ph);
        col = (st == 0) ? ph : 1'b1;
        return {eh, 4'(dh / 10), 1'b0, eh, 4'(dh % 10), col, 6'd0,
                em, 4'(m / 10), col, em, 4'(m % 10), 1'b0, 6'd0,
                es, 4'(s / 10), 1'b0, es, 4'(s % 10), h12 & pm};
    endfunction

    task automatic model_reset();
        m_st = 0; m_h = 23; m_m = 59; m_s = 58; m_ph = 1'b1; m_tc = 0;
        pv_mode = 1'b0; pv_add = 1'b0; pv_sub = 1'b0;
        r_act = 1'b0; r_up = 1'b0; r_n = 0;
        x24 = model_disp(1'b0, 0, 23, 59, 58, 1'b1);
        x12 = model_disp(1'b1, 0, 23, 59, 58, 1'b1);
        xh = 23; xm = 59; xs = 58;
    endtask

    task automatic model_step();
        bit me, ae, se, anye, edit, to, fire, held, up;
        int t, n, v;
        me   = mode_button && !pv_mode;
        ae   = add_button && !pv_add;
        se   = sub_button && !pv_sub;
        anye = me || ae || se;
        edit = ae ^ se;
        x24 = model_disp(1'b0, m_st, m_h, m_m, m_s, m_ph);
        x12 = model_disp(1'b1, m_st, m_h, m_m, m_s, m_ph);
        xh = m_h; xm = m_m; xs = m_s;
        to   = (m_st != 0) && (m_tc == TO);
        held = r_up ? add_button : sub_button;
`ifdef WATCH_HOLD_REPEAT_EN
        fire = r_act && held && pulse_500ms && (r_n >= 2);
`else
        fire = 1'b0;
`endif
        if (m_st == 0 && pulse_1hz) begin
            t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
        end else if (m_st != 0 && !me && !to && (edit || fire)) begin
            up = edit ? ae : r_up;
            n  = (m_st == 1) ? 24 : 60;
            v  = (m_st == 1) ? m_h : (m_st == 2) ? m_m : m_s;
            v  = (v + (up ? 1 : n - 1)) % n;
            case (m_st)
                1: m_h = v;
                2: m_m = v;
                default: m_s = v;
            endcase
        end
        if (m_st == 0 || me || to) r_act = 1'b0;
        else if (edit) begin r_act = 1'b1; r_up = ae; r_n = 0; end
        else if (ae && se) r_act = 1'b0;
        else if (r_act && !held) r_act = 1'b0;
        else if (r_act && pulse_500ms) r_n++;
        if (me || to || anye) m_tc = 0;
        else if (m_st != 0 && pulse_1hz && m_tc < TO) m_tc++;
        if (me) m_st = (m_st + 1) % 4;
        else if (to) m_st = 0;
        if (anye) m_ph = 1'b1;
        else if (pulse_500ms) m_ph = !m_ph;
        pv_mode = mode_button; pv_add = add_button; pv_sub = sub_button;
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        #1;
        if (cmp_en) begin
            check("disp24", {a8, a7, a6, a5, a4, a3, a2, a1}, x24);
            check("disp12", {b8, b7, b6, b5, b4, b3, b2, b1}, x12);
            check("hours_a", 48'(hours_a), 48'(xh));
            check("hours_b", 48'(hours_b), 48'(xh));
            check("minutes", 48'(minutes_a), 48'(xm));
            check("seconds", 48'(seconds_a), 48'(xs));
            check("set_active", 48'(set_active_a), 48'(m_st != 0));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input int which);
        case (which)
            0: mode_button = 1'b1;
            1: add_button = 1'b1;
            default: sub_button = 1'b1;
        endcase
        step(1);
        mode_button = 1'b0; add_button = 1'b0; sub_button = 1'b0;
        step(1);
    endtask

    task automatic p1();
        pulse_1hz = 1'b1; step(1); pulse_1hz = 1'b0; step(1);
    endtask

    task automatic p5();
        pulse_500ms = 1'b1; step(1); pulse_500ms = 1'b0; step(1);
    endtask

    initial begin
        step(3);
        reset = 1'b1;
        cmp_en = 1'b1;
        step(1);
        // Reset state: 23:59:58
        check("rst_hours", 48'(hours_a), 48'd23);
        check("rst_seconds", 48'(seconds_a), 48'd58);
        check("rst_set_active", 48'(set_active_a), 48'd0);
        check("rst_d8", 48'(a8), 48'h24);
        check("rst_d7", 48'(a7), 48'h27);
        check("rst_d1", 48'(a1), 48'h30);
        check("rst_d8_12h", 48'(b8), 48'h22);
        check("rst_d1_12h", 48'(b1), 48'h31);

        p1();
        check("ss_59", 48'(seconds_a), 48'd59);
        p1();
        check("wrap_hours", 48'(hours_a), 48'd0);
        check("wrap_minutes", 48'(minutes_a), 48'd0);
        check("wrap_seconds", 48'(seconds_a), 48'd0);
        check("zero_d8", 48'(a8), 48'h20);
        check("zero_d7", 48'(a7), 48'h21);
        check("zero_d1", 48'(a1), 48'h20);
        check("h12_d8", 48'(b8), 48'h22);
        check("h12_d7", 48'(b7), 48'h25);
        check("h12_d1_am", 48'(b1), 48'h20);

        // Set hours: 0 -> 22 -> 1, frozen seconds
        press(0);
        check("set_active_hh", 48'(set_active_a), 48'd1);
        press(2); press(2);
        check("hh_22", 48'(hours_a), 48'd22);
        press(1); press(1); press(1);
        check("hh_1", 48'(hours_a), 48'd1);
        check("hh_mm_kept", 48'(minutes_a), 48'd0);
        p1();
        check("ss_frozen", 48'(seconds_a), 48'd0);
        for (int i = 0; i < 12; i++) press(1);
        check("hh_13", 48'(hours_a), 48'd13);
        check("hh_13_12h_out", 48'(hours_b), 48'd13);
        check("h12_d8_01", 48'(b8), 48'h20);
        check("h12_d1_pm", 48'(b1), 48'h21);

        // Set minutes: borrow-free wrap, then mode beats add
        press(0);
        press(2);
        check("mm_59", 48'(minutes_a), 48'd59);
        check("mm_no_borrow", 48'(hours_a), 48'd13);
        mode_button = 1'b1; add_button = 1'b1; step(1);
        mode_button = 1'b0; add_button = 1'b0; step(1);
        check("mode_add_mm", 48'(minutes_a), 48'd59);
        p5();
        check("blink_d2", 48'(a2), 48'h00);
        check("blink_d4", 48'(a4), 48'h32);

        // Timeout with restart
        p1(); p1();
        press(1);
        check("ss_add", 48'(seconds_a), 48'd1);
        p1(); p1();
        check("to_restart", 48'(set_active_a), 48'd1);
        p1();
        check("to_run", 48'(set_active_a), 48'd0);
        check("colon_on", 48'(a7), 48'h27);
        p5();
        check("colon_off_d7", 48'(a7), 48'h26);
        check("colon_off_d5", 48'(a5), 48'h2A);

        // Asynchronous reset mid-edit
        press(0); press(1);
        reset = 1'b0;
        #1;
        check("async_set_active", 48'(set_active_a), 48'd0);
        check("async_hours", 48'(hours_a), 48'd23);
        check("async_d8", 48'(a8), 48'h24);
        step(1);
        reset = 1'b1;
        step(1);

        // Held add in set minutes
        press(0); press(0);
        for (int i = 0; i < 11; i++) press(1);
        check("mm_10", 48'(minutes_a), 48'd10);
        add_button = 1'b1;
        step(2);
        for (int i = 0; i < 5; i++) p5();
        step(1);
`ifdef WATCH_HOLD_REPEAT_EN
        check("hold_repeat", 48'(minutes_a), 48'd14);
`else
        check("hold_no_repeat", 48'(minutes_a), 48'd11);
`endif
        add_button = 1'b0;
        step(1);
        p5(); p5();
`ifdef WATCH_HOLD_REPEAT_EN
        check("release_stop", 48'(minutes_a), 48'd14);
`else
        check("release_stop", 48'(minutes_a), 48'd11);
`endif

        // Randomised run against the model
        for (int i = 0; i < 4000; i++) begin
            pulse_1hz   = ($urandom_range(0, 7) == 0);
            pulse_500ms = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) mode_button = ~mode_button;
            if ($urandom_range(0, 5) == 0) add_button = ~add_button;
            if ($urandom_range(0, 5) == 0) sub_button = ~sub_button;
            reset = ($urandom_range(0, 999) != 0);
            step(1);
        end
        reset = 1'b1;
        pulse_1hz = 1'b0; pulse_500ms = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
